// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM state type, PC step, NOP word and alignment mask.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] NOP           = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: async reset, word-aligned load with priority over +4 increment.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [31:0] i_loadVal,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcPlus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pcPlus4;

    // Wraps modulo 2^32 with no carry out.
    assign w_pcPlus4 = r_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_loadVal & PC_ALIGN_MASK;
        end else if (i_inc) begin
            r_pc <= w_pcPlus4;
        end
    end

    assign o_pc      = r_pc;
    assign o_pcPlus4 = w_pcPlus4;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: memory request/response FSM feeding the IR with a one-cycle irWrite strobe.
// Optional memReady timeout (fetchErr port) enabled by defining INST_FETCH_TIMEOUT_EN.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetchEn,
    input  logic        pcWrite,
    input  logic [31:0] pcNext,
    output logic [31:0] memAddr,
    output logic        memRead,
    input  logic        memReady,
    input  logic [31:0] memData,
    output logic [31:0] inst,
    output logic        irWrite,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        busy
`ifdef INST_FETCH_TIMEOUT_EN
    ,
    output logic        fetchErr
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_next;

    logic [31:0] r_memAddr;
    logic [31:0] r_inst;
    logic        r_memRead;
    logic        r_irWrite;
    logic        w_timeout;
    logic        w_pcInc;
    logic [31:0] w_pc;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_waitCnt;
    logic             r_timedOut;
    logic             r_fetchErr;

    assign w_timeout = (r_state == REQ) && !memReady && (r_waitCnt == CNT_LAST);

    // r_timedOut spans LATCH and WRITE so it can both raise fetchErr and suppress the +4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt  <= '0;
            r_timedOut <= 1'b0;
            r_fetchErr <= 1'b0;
        end else begin
            r_waitCnt  <= (r_state == REQ) ? r_waitCnt + CNT_W'(1) : '0;
            r_fetchErr <= (r_state == LATCH) && r_timedOut;
            if (w_timeout) begin
                r_timedOut <= 1'b1;
            end else if (r_state == WRITE) begin
                r_timedOut <= 1'b0;
            end
        end
    end

    assign w_pcInc  = (r_state == WRITE) && !r_timedOut;
    assign fetchErr = r_fetchErr;
`else
    assign w_timeout = 1'b0;
    assign w_pcInc   = (r_state == WRITE);
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (fetchEn) w_next = REQ;
            REQ:     if (memReady || w_timeout) w_next = LATCH;
            LATCH:   w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_memAddr <= RESET_PC;
            r_inst    <= NOP;
            r_memRead <= 1'b0;
            r_irWrite <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_memRead <= (w_next == REQ);
            r_irWrite <= (w_next == WRITE);
            if ((r_state == IDLE) && fetchEn) begin
                r_memAddr <= w_pc;
            end
            if (r_state == REQ) begin
                if (memReady) begin
                    r_inst <= memData;
                end else if (w_timeout) begin
                    r_inst <= NOP;
                end
            end
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc     (w_pcInc),
        .i_load    (pcWrite),
        .i_loadVal (pcNext),
        .o_pc      (w_pc),
        .o_pcPlus4 (pcPlus4)
    );

    assign pc      = w_pc;
    assign memAddr = r_memAddr;
    assign memRead = r_memRead;
    assign inst    = r_inst;
    assign irWrite = r_irWrite;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the fetch protocol.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int unsigned TIMEOUT = 16;
`ifdef INST_FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetchEn = 1'b0;
    logic        pcWrite = 1'b0;
    logic [31:0] pcNext = '0;
    logic        memReady = 1'b0;
    logic [31:0] memData = '0;
    logic [31:0] memAddr;
    logic        memRead;
    logic [31:0] inst;
    logic        irWrite;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        busy;
    logic        fetchErr;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetchEn  (fetchEn),
        .pcWrite  (pcWrite),
        .pcNext   (pcNext),
        .memAddr  (memAddr),
        .memRead  (memRead),
        .memReady (memReady),
        .memData  (memData),
        .inst     (inst),
        .irWrite  (irWrite),
        .pc       (pc),
        .pcPlus4  (pcPlus4),
        .busy     (busy)
`ifdef INST_FETCH_TIMEOUT_EN
        ,
        .fetchErr (fetchErr)
`endif
    );

`ifndef INST_FETCH_TIMEOUT_EN
    assign fetchErr = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a fetch is a transaction with a phase number
    // (0 none, 1 awaiting memory, 2 word held, 3 delivery cycle).
    int unsigned m_phase;
    int unsigned m_wait;
    logic [31:0] m_pc, m_inst, m_addr;
    bit          m_to;
    bit          mdl_valid = 1'b0;
    logic        prev_ir = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_wait    <= 0;
            m_pc      <= RST_PC;
            m_inst    <= '0;
            m_addr    <= RST_PC;
            m_to      <= 1'b0;
            mdl_valid <= 1'b1;
        end else begin
            if (pcWrite) m_pc <= pcNext & 32'hFFFF_FFFC;
            else if (m_phase == 3 && !m_to) m_pc <= m_pc + 32'd4;
            case (m_phase)
                0: if (fetchEn) begin
                    m_phase <= 1;
                    m_addr  <= m_pc;
                    m_wait  <= 0;
                end
                1: if (memReady) begin
                    m_inst  <= memData;
                    m_phase <= 2;
                end else if (TO_EN && (m_wait + 1 == TIMEOUT)) begin
                    m_inst  <= '0;
                    m_to    <= 1'b1;
                    m_phase <= 2;
                end else begin
                    m_wait <= m_wait + 1;
                end
                2: m_phase <= 3;
                default: begin
                    m_phase <= 0;
                    m_to    <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mdl_valid) begin
            check("memRead",  memRead,  m_phase == 1);
            check("irWrite",  irWrite,  m_phase == 3);
            check("busy",     busy,     m_phase != 0);
            check("memAddr",  memAddr,  m_addr);
            check("inst",     inst,     m_inst);
            check("pc",       pc,       m_pc);
            check("pcPlus4",  pcPlus4,  m_pc + 32'd4);
            check("fetchErr", fetchErr, (m_phase == 3) && m_to);
            check("irWrite_repeat", irWrite & prev_ir, 1'b0);
            prev_ir <= irWrite;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        fetchEn = 0; pcWrite = 0; memReady = 0; pcNext = '0; memData = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic fetch_once(input logic [31:0] d);
        memReady = 1; memData = d; fetchEn = 1;
        @(negedge clk);
        fetchEn = 0;
        repeat (3) @(negedge clk);
        memReady = 0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pcWrite = 1; pcNext = v;
        @(negedge clk);
        pcWrite = 0;
    endtask

    initial begin
        int          pulses[$];
        logic [31:0] addrs[$];
        int          n_rd;
        int          ir_k;
        bit          addr_ok;

        // Reset values
        do_reset();
        check("rst_pc", pc, RST_PC);
        check("rst_memAddr", memAddr, RST_PC);
        check("rst_inst", inst, 32'h0);
        check("rst_busy", busy, 1'b0);

        // Single zero-wait fetch
        memData = 32'h8C22_0004; memReady = 1; fetchEn = 1;
        @(negedge clk);
        fetchEn = 0;
        check("t1_memRead", memRead, 1'b1);
        check("t1_memAddr", memAddr, 32'h0);
        @(negedge clk);
        check("t1_inst_latch", inst, 32'h8C22_0004);
        check("t1_ir_latch", irWrite, 1'b0);
        @(negedge clk);
        check("t1_ir_c3", irWrite, 1'b1);
        check("t1_pc_c3", pc, 32'h0);
        @(negedge clk);
        check("t1_pc_after", pc, 32'h4);
        check("t1_ir_after", irWrite, 1'b0);
        memReady = 0;

        // Three back-to-back fetches
        do_reset();
        memReady = 1; fetchEn = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            memData = 32'hC0DE_0000 | memAddr;
            if (irWrite) pulses.push_back(k);
            if (memRead) addrs.push_back(memAddr);
            if (k == 11) fetchEn = 0;
        end
        check("t2_pulses", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("t2_p0", pulses[0], 3);
            check("t2_p1", pulses[1], 7);
            check("t2_p2", pulses[2], 11);
        end
        check("t2_reqs", addrs.size(), 3);
        if (addrs.size() == 3) begin
            check("t2_a0", addrs[0], 32'h0);
            check("t2_a1", addrs[1], 32'h4);
            check("t2_a2", addrs[2], 32'h8);
        end
        check("t2_pc", pc, 32'hC);
        check("t2_inst", inst, 32'hC0DE_0008);
        memReady = 0;

        // memReady delayed 5 cycles
        do_reset();
        load_pc(32'h0000_0200);
        memData = 32'h1234_5678; memReady = 0; fetchEn = 1;
        n_rd = 0; ir_k = -1; addr_ok = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            fetchEn = 0;
            if (memRead) begin
                n_rd++;
                if (memAddr !== 32'h200) addr_ok = 1'b0;
            end
            if (irWrite && ir_k < 0) ir_k = k;
            memReady = (k == 6);
        end
        check("t3_memRead_cycles", n_rd, 6);
        check("t3_addr_stable", addr_ok, 1'b1);
        check("t3_ir_cycle", ir_k, 8);
        check("t3_inst", inst, 32'h1234_5678);
        check("t3_pc", pc, 32'h204);

        // pcWrite in WRITE wins over increment
        do_reset();
        memReady = 1; memData = 32'hAAAA_0001; fetchEn = 1;
        @(negedge clk);
        fetchEn = 0;
        repeat (2) @(negedge clk);
        check("t4_ir", irWrite, 1'b1);
        pcWrite = 1; pcNext = 32'h0000_0103;
        @(negedge clk);
        pcWrite = 0;
        check("t4_pc_load", pc, 32'h100);
        fetchEn = 1;
        @(negedge clk);
        fetchEn = 0;
        check("t4_memAddr", memAddr, 32'h100);
        repeat (3) @(negedge clk);
        check("t4_pc_next", pc, 32'h104);
        memReady = 0;

        // PC wrap and reset mid-REQ
        load_pc(32'hFFFF_FFFF);
        check("t5_pc_top", pc, 32'hFFFF_FFFC);
        check("t5_plus4_wrap", pcPlus4, 32'h0);
        fetch_once(32'h0BAD_F00D);
        check("t5_pc_wrap", pc, 32'h0);
        load_pc(32'h0000_0040);
        memReady = 0; fetchEn = 1;
        @(negedge clk);
        fetchEn = 0;
        @(negedge clk);
        check("t5_in_req", memRead, 1'b1);
        #2 rst_n = 0;
        #1;
        check("t5_rst_memRead", memRead, 1'b0);
        check("t5_rst_irWrite", irWrite, 1'b0);
        check("t5_rst_pc", pc, RST_PC);
        check("t5_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1;

`ifdef INST_FETCH_TIMEOUT_EN
        // Memory never answers
        fetch_once(32'hDEAD_BEEF);
        load_pc(32'h0000_0080);
        memReady = 0; fetchEn = 1;
        n_rd = 0; ir_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            fetchEn = 0;
            if (memRead) n_rd++;
            if (irWrite && ir_k < 0) begin
                ir_k = k;
                check("t6_fetchErr", fetchErr, 1'b1);
                check("t6_inst_nop", inst, 32'h0);
            end
            if (k == 19) check("t6_fetchErr_clear", fetchErr, 1'b0);
        end
        check("t6_memRead_cycles", n_rd, 16);
        check("t6_ir_cycle", ir_k, 18);
        check("t6_pc_hold", pc, 32'h80);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            fetchEn  = ($urandom_range(0, 9) < 7);
            memReady = ($urandom_range(0, 9) < 5);
            memData  = $urandom();
            pcWrite  = ($urandom_range(0, 9) == 0);
            pcNext   = $urandom();
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
